// File: rtl/nibble_packer.sv
// Packs RATIO consecutive DATA_W-bit words (LSB lane first) into one registered output word.
// Optional NIBBLE_PACKER_FLUSH_EN adds flush/out_keep for emitting partial words.

module nibble_packer_lane #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (we) q <= d;
  end
endmodule

module nibble_packer #(
  parameter int DATA_W = 4,
  parameter int RATIO  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_W*RATIO-1:0] out_data,
  output logic                    out_valid,
`ifdef NIBBLE_PACKER_FLUSH_EN
  input  logic                    flush,
  output logic [RATIO-1:0]        out_keep,
`endif
  input  logic                    out_ready
);
  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] LAST = CW'(RATIO-1);

  logic [CW-1:0]                  cnt;
  logic [RATIO-2:0][DATA_W-1:0]   acc;
  logic [RATIO-2:0]               lane_we;
  logic                           in_beat, out_beat, final_beat, base_ready;

  // Only the closing lane can stall: it needs the output register free.
  assign base_ready = (cnt != LAST) || !out_valid || out_ready;
  assign in_beat    = in_valid && in_ready;
  assign out_beat   = out_valid && out_ready;
  assign final_beat = in_beat && (cnt == LAST);

  // Top lane never lands in acc; it goes straight into out_data.
  for (genvar g = 0; g < RATIO-1; g++) begin : g_lane
    assign lane_we[g] = in_beat && (cnt == CW'(g));
    nibble_packer_lane #(.DATA_W(DATA_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .we    (lane_we[g]),
      .d     (in_data),
      .q     (acc[g])
    );
  end

`ifdef NIBBLE_PACKER_FLUSH_EN
  logic                         pending, flush_fire;
  logic [RATIO-1:0]             fill_mask;
  logic [RATIO-1:0][DATA_W-1:0] flush_word;

  assign in_ready   = base_ready && !pending;
  assign flush_fire = pending && (!out_valid || out_ready);

  always_comb begin
    fill_mask  = '0;
    flush_word = '0;
    for (int k = 0; k < RATIO-1; k++) begin
      fill_mask[k] = (k < int'(cnt));
      if (fill_mask[k]) flush_word[k] = acc[k];
    end
  end

  // A flush that lands on the closing beat is satisfied by the full word itself.
  always_ff @(posedge clk) begin
    if (reset)                                              pending <= 1'b0;
    else if (flush_fire)                                    pending <= 1'b0;
    else if (flush && (cnt != '0 || in_beat) && !final_beat) pending <= 1'b1;
  end
`else
  assign in_ready = base_ready;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef NIBBLE_PACKER_FLUSH_EN
      out_keep  <= '0;
`endif
    end else begin
      if (in_beat) cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
`ifdef NIBBLE_PACKER_FLUSH_EN
      else if (flush_fire) cnt <= '0;
`endif

      if (final_beat) begin
        out_data  <= {in_data, acc};
        out_valid <= 1'b1;
`ifdef NIBBLE_PACKER_FLUSH_EN
        out_keep  <= '1;
      end else if (flush_fire) begin
        out_data  <= flush_word;
        out_valid <= 1'b1;
        out_keep  <= fill_mask;
`endif
      end else if (out_beat) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Downstream consumer of the single-entry nibble buffer stage.
- Accepts DATA_W-bit words over a valid/ready handshake and packs RATIO consecutive words into one DATA_W*RATIO-bit word.
- Presents the packed word on a registered valid/ready output port to the next stage.
- Sustains one input word per cycle when the output side is not back-pressured.

Parameters:
- DATA_W, 4, width of one input word (nibble).
- RATIO, 4, input words per packed output word; legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  input word; sampled on an accepted beat.
- in_valid  input  1  upstream has a word (driven by the buffer stage's v_out).
- in_ready  output  1  this block accepts a word this cycle (drives the buffer stage's ready input).
- out_data  output  DATA_W*RATIO  packed word, registered.
- out_valid  output  1  out_data holds a packed word.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Interface decision: reset is reset, synchronous, active-high; clock is clk.
- Reset values: out_valid=0, out_data=0, lane counter cnt=0, accumulator=0. Reset overrides every other event, including mid-word reset; partial words are discarded.
- Input beat: in_valid && in_ready at a rising edge.
- Output beat: out_valid && out_ready at a rising edge.
- Lane order is LSB-first. Beat k of a word goes to accumulator bits [k*DATA_W +: DATA_W].
- cnt counts 0..RATIO-1 and increments on each input beat. It wraps to 0 on the beat that fills lane RATIO-1.
- Final beat (cnt==RATIO-1): at that edge, out_data <= {in_data, accumulator lanes 0..RATIO-2} and out_valid <= 1. The packed word is visible the cycle after the final beat (latency 1).
- in_ready = (cnt != RATIO-1) || !out_valid || out_ready. This is combinational on out_ready.
  - Lanes 0..RATIO-2 are always accepted.
  - The final lane stalls only while a previous packed word is still waiting.
- Simultaneous output beat and final input beat: out_data loads the new word and out_valid stays 1, giving no bubble.
- Output beat with no final input beat: out_valid <= 0. out_data holds its value (don't-care).
- Stability: while out_valid && !out_ready, out_data and out_valid do not change.
- in_data is ignored when in_valid is low. No beat is accepted when in_valid=1 and in_ready=0.
- Throughput: one packed word every RATIO cycles at full rate.

Optional Feature:
- Macro NIBBLE_PACKER_FLUSH_EN adds two ports:
  - flush input 1, a single-cycle request.
  - out_keep output RATIO, with bit k set when lane k of out_data is valid.
- A flush with cnt>0, or coinciding with an input beat, sets a sticky pending flag.
- While pending:
  - in_ready=0.
  - On the first edge with !out_valid || out_ready, out_data <= accumulator with unfilled lanes zero, out_keep = lanes filled, out_valid <= 1.
  - At that same edge, cnt <= 0 and the pending flag clears.
- An input beat accepted in the same cycle as flush is included in the flushed word.
- Flush with cnt==0 and no input beat is ignored.
- Full words set out_keep to all ones. Reset sets out_keep=0 and clears the pending flag.
- Without the macro: no flush or out_keep ports; only full words are emitted.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=1, nothing accepted; release -> first beat goes to lane 0.
- Streaming: in_valid=1 with data 1,2,3,4,5,6,7,8 on consecutive cycles, out_ready=1 -> out_data=16'h4321 one cycle after beat 4, then 16'h8765 one cycle after beat 8; in_ready never drops.
- Back-pressure: out_ready=0 while 8 nibbles 1..8 are offered -> 16'h4321 held stable; in_ready=0 with cnt==3 and data 8 offered; raise out_ready -> 16'h4321 consumed, 16'h8765 appears next cycle, no loss or duplication.
- Gapped input: in_valid pulses 1 of every 3 cycles with data A,B,C,D -> single out_data=16'hDCBA; out_valid pulses only once.
- Mid-word reset: accept 2,3, assert reset, then send 4,5,6,7 -> out_data=16'h7654; no lane from 2,3 appears.
- Flush (NIBBLE_PACKER_FLUSH_EN): accept 9,A, pulse flush with out_ready=1 -> out_data=16'h00A9, out_keep=4'b0011; in_ready low until emitted; next word starts at lane 0.
